// File: rtl/imem_ctrl_pkg.sv
// Shared types and default parameters for the instruction-memory boot/access controller.
package imem_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun
  } state_e;

  localparam int unsigned DEPTH_DEF    = 1024;
  localparam logic [31:0] START_PC_DEF = 32'h0000_0000;
  localparam int unsigned MAX_WAIT_DEF = 4;
  localparam int unsigned IDX_W_DEF    = $clog2(DEPTH_DEF);

endpackage

// File: rtl/imem_dbg_arb.sv
// Debug read arbiter: bounded-wait grant against instruction fetch, no back-to-back grants,
// registered read-data return.
module imem_dbg_arb
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_pc_en,
  input  logic        i_dbg_req,
  input  logic [31:0] i_mem_rdata,
  output logic        o_dbg_gnt,
  output logic [31:0] o_dbg_rdata,
  output logic        o_dbg_rvalid
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 2);

  logic [WAIT_W-1:0] r_wait;
  logic [31:0]       r_rdata;
  logic              r_rvalid;
  logic              w_gnt;
  logic              w_wait_max;

  assign w_wait_max = (r_wait == WAIT_W'(MAX_WAIT));
  // r_rvalid doubles as "granted last cycle", which blocks back-to-back grants.
  assign w_gnt = i_en & i_dbg_req & ~r_rvalid & (~i_pc_en | w_wait_max);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wait   <= '0;
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_gnt;
      if (w_gnt) begin
        r_rdata <= i_mem_rdata;
      end
      if (!i_en || !i_dbg_req || w_gnt) begin
        r_wait <= '0;
      end else if (!w_wait_max) begin
        r_wait <= r_wait + 1'b1;
      end
    end
  end

  assign o_dbg_gnt    = w_gnt;
  assign o_dbg_rdata  = r_rdata;
  assign o_dbg_rvalid = r_rvalid;

endmodule

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: boot loader FSM, PC ownership, and fetch/debug port muxing.
module imem_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter logic [31:0] START_PC = START_PC_DEF,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ld_start,
  input  logic        i_ld_valid,
  input  logic [31:0] i_ld_data,
  input  logic        i_ld_last,
  output logic        o_ld_ready,
  output logic        o_load_err,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_core_rst_n,
  output logic [31:0] o_pc,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  input  logic        i_pc_en,
  input  logic [31:0] i_pc_next,
  input  logic        i_dbg_req,
  input  logic [31:0] i_dbg_addr,
  output logic        o_dbg_gnt,
  output logic [31:0] o_dbg_rdata,
  output logic        o_dbg_rvalid
);

  localparam int unsigned IdxW = $clog2(DEPTH);

  state_e            r_state;
  state_e            w_state_d;
  logic [IdxW-1:0]   r_cnt;
  logic              r_load_err;
  logic [31:0]       r_pc;
  logic              r_core_rst_n;
  logic              w_accept;
  logic              w_overflow;
  logic              w_run;
  logic              w_dbg_gnt;
  logic              w_instr_valid;

  always_comb begin
    w_state_d  = r_state;
    w_accept   = 1'b0;
    w_overflow = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_ld_start) w_state_d = StLoad;
      end
      StLoad: begin
        w_accept = i_ld_valid;
        if (w_accept) begin
          if (i_ld_last) begin
            w_state_d = StRun;
          end else if (r_cnt == IdxW'(DEPTH - 1)) begin
            w_state_d  = StRun;
            w_overflow = 1'b1;
          end
        end
      end
      StRun: begin
        if (i_ld_start) w_state_d = StLoad;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_run         = (r_state == StRun);
  assign w_instr_valid = w_run & ~w_dbg_gnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= StIdle;
      r_cnt        <= '0;
      r_load_err   <= 1'b0;
      r_pc         <= START_PC;
      r_core_rst_n <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      // Core leaves reset one cycle after RUN entry and re-enters it with the LOAD transition.
      r_core_rst_n <= w_run && (w_state_d == StRun);
      if (r_state != StLoad && w_state_d == StLoad) begin
        r_cnt      <= '0;
        r_load_err <= 1'b0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_overflow) begin
        r_load_err <= 1'b1;
      end
      if (!w_run && w_state_d == StRun) begin
        r_pc <= START_PC;
      end else if (w_run && i_pc_en && w_instr_valid) begin
        r_pc <= i_pc_next;
      end
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_we    = 1'b0;
    o_mem_wdata = '0;
    if (r_state == StLoad) begin
      o_mem_addr  = {{(30 - IdxW){1'b0}}, r_cnt, 2'b00};
      o_mem_we    = w_accept;
      o_mem_wdata = w_accept ? i_ld_data : 32'h0;
    end else if (w_run) begin
      o_mem_addr = w_dbg_gnt ? i_dbg_addr : r_pc;
    end
  end

  imem_dbg_arb #(
    .MAX_WAIT(MAX_WAIT)
  ) u_dbg_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (w_run),
    .i_pc_en     (i_pc_en),
    .i_dbg_req   (i_dbg_req),
    .i_mem_rdata (i_mem_rdata),
    .o_dbg_gnt   (w_dbg_gnt),
    .o_dbg_rdata (o_dbg_rdata),
    .o_dbg_rvalid(o_dbg_rvalid)
  );

  assign o_ld_ready    = (r_state == StLoad);
  assign o_load_err    = r_load_err;
  assign o_core_rst_n  = r_core_rst_n;
  assign o_pc          = r_pc;
  assign o_instr_valid = w_instr_valid;
  assign o_instr       = w_instr_valid ? i_mem_rdata : 32'h0;
  assign o_dbg_gnt     = w_dbg_gnt;

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: boot load, fetch, debug arbitration, overflow load, mid-load reset.
module tb_imem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start, ld_valid, ld_last, ld_ready, load_err;
  logic [31:0] ld_data;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, core_rst_n;
  logic [31:0] pc, instr, pc_next, dbg_addr, dbg_rdata;
  logic        instr_valid, pc_en, dbg_req, dbg_gnt, dbg_rvalid;

  always #5 clk = ~clk;

  imem_ctrl #(
    .DEPTH   (1024),
    .START_PC(32'h0000_0000),
    .MAX_WAIT(4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_ld_start   (ld_start),
    .i_ld_valid   (ld_valid),
    .i_ld_data    (ld_data),
    .i_ld_last    (ld_last),
    .o_ld_ready   (ld_ready),
    .o_load_err   (load_err),
    .o_mem_addr   (mem_addr),
    .o_mem_we     (mem_we),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_core_rst_n (core_rst_n),
    .o_pc         (pc),
    .o_instr      (instr),
    .o_instr_valid(instr_valid),
    .i_pc_en      (pc_en),
    .i_pc_next    (pc_next),
    .i_dbg_req    (dbg_req),
    .i_dbg_addr   (dbg_addr),
    .o_dbg_gnt    (dbg_gnt),
    .o_dbg_rdata  (dbg_rdata),
    .o_dbg_rvalid (dbg_rvalid)
  );

  // Instruction memory array: synchronous write, combinational read.
  logic [31:0] mem [1024];
  always @(posedge clk) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
  assign mem_rdata = mem[mem_addr[11:2]];
  assign pc_next   = pc + 32'd4;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    pc_en = 0; dbg_req = 0; dbg_addr = '0;
    tick(); tick();
    chk("rst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    chk("rst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_dbg", {30'b0, dbg_gnt, dbg_rvalid}, 32'd0);
    chk("rst_load_err", {31'b0, load_err}, 32'd0);
    chk("rst_pc", pc, 32'h0);

    // Boot load of three words.
    rst = 1'b1; tick();
    ld_start = 1; tick(); ld_start = 0;
    ld_valid = 1; ld_data = 32'h0064A423; #1;
    chk("ld_ready", {31'b0, ld_ready}, 32'd1);
    chk("ld0_we", {31'b0, mem_we}, 32'd1);
    chk("ld0_addr", mem_addr, 32'h0);
    chk("ld0_wdata", mem_wdata, 32'h0064A423);
    tick(); ld_data = 32'hFFC4A303; #1;
    chk("ld1_addr", mem_addr, 32'h4);
    tick(); ld_data = 32'h00000013; ld_last = 1; #1;
    chk("ld2_addr", mem_addr, 32'h8);
    tick(); ld_valid = 0; ld_last = 0; #1;
    chk("run_entry_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    chk("run_entry_pc", pc, 32'h0);
    chk("run_entry_instr", instr, 32'h0064A423);
    chk("run_entry_ld_ready", {31'b0, ld_ready}, 32'd0);
    tick();
    chk("core_rst_n_high", {31'b0, core_rst_n}, 32'd1);

    // Sequential fetch.
    pc_en = 1; #1;
    chk("fetch0", instr, 32'h0064A423);
    tick();
    chk("fetch1_pc", pc, 32'h4);
    chk("fetch1", instr, 32'hFFC4A303);
    tick();
    chk("fetch2", instr, 32'h00000013);
    tick();

    // Debug against continuous fetch: forced through on the 5th request cycle.
    dbg_req = 1; dbg_addr = 32'h8; #1;
    chk("dbg_wait1_gnt", {31'b0, dbg_gnt}, 32'd0);
    chk("dbg_wait1_pc", pc, 32'd12);
    tick(); tick(); tick();
    chk("dbg_wait4_gnt", {31'b0, dbg_gnt}, 32'd0);
    tick();
    chk("dbg_force_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("dbg_force_iv", {31'b0, instr_valid}, 32'd0);
    chk("dbg_force_addr", mem_addr, 32'h8);
    chk("dbg_force_pc", pc, 32'd28);
    tick(); dbg_req = 0; #1;
    chk("dbg_force_pc_hold", pc, 32'd28);
    chk("dbg_force_rvalid", {31'b0, dbg_rvalid}, 32'd1);
    chk("dbg_force_rdata", dbg_rdata, 32'h00000013);
    chk("dbg_force_gnt_after", {31'b0, dbg_gnt}, 32'd0);
    tick();

    // Debug while core stalled: immediate grant, no back-to-back.
    pc_en = 0; dbg_req = 1; dbg_addr = 32'h4; #1;
    chk("dbg_idle_pc", pc, 32'd32);
    chk("dbg_idle_gnt", {31'b0, dbg_gnt}, 32'd1);
    chk("dbg_idle_addr", mem_addr, 32'h4);
    tick();
    chk("dbg_b2b_gnt", {31'b0, dbg_gnt}, 32'd0);
    chk("dbg_b2b_iv", {31'b0, instr_valid}, 32'd1);
    chk("dbg_idle_rvalid", {31'b0, dbg_rvalid}, 32'd1);
    chk("dbg_idle_rdata", dbg_rdata, 32'hFFC4A303);
    chk("dbg_b2b_pc", pc, 32'd32);
    tick();
    chk("dbg_regrant", {31'b0, dbg_gnt}, 32'd1);
    dbg_req = 0;
    tick();

    // Reload from RUN, never asserting ld_last: overflow after DEPTH words.
    ld_start = 1; tick(); ld_start = 0;
    chk("reload_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    chk("reload_ld_ready", {31'b0, ld_ready}, 32'd1);
    ld_valid = 1;
    for (int i = 0; i < 1024; i++) begin
      ld_data = 32'hA500_0000 | i;
      if (i == 1023) begin
        #1;
        chk("ovf_last_addr", mem_addr, 32'hFFC);
      end
      tick();
    end
    ld_valid = 0; #1;
    chk("ovf_load_err", {31'b0, load_err}, 32'd1);
    chk("ovf_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("ovf_pc", pc, 32'h0);
    chk("ovf_instr", instr, 32'hA500_0000);
    tick();

    // Reset in the middle of a load.
    ld_start = 1; tick(); ld_start = 0;
    chk("reload2_err_cleared", {31'b0, load_err}, 32'd0);
    ld_valid = 1; dbg_req = 1; dbg_addr = 32'h0;
    ld_data = 32'h1111_1111; #1;
    chk("load_no_dbg_gnt", {31'b0, dbg_gnt}, 32'd0);
    tick(); ld_data = 32'h2222_2222; #1;
    chk("midload_addr", mem_addr, 32'h4);
    tick(); ld_valid = 0; dbg_req = 0; rst = 0;
    tick();
    chk("midrst_ld_ready", {31'b0, ld_ready}, 32'd0);
    chk("midrst_core_rst_n", {31'b0, core_rst_n}, 32'd0);
    chk("midrst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("midrst_pc", pc, 32'h0);
    rst = 1; tick();
    ld_start = 1; tick(); ld_start = 0;
    ld_valid = 1; ld_data = 32'h3333_3333; #1;
    chk("restart_addr", mem_addr, 32'h0);
    chk("restart_we", {31'b0, mem_we}, 32'd1);
    tick(); ld_valid = 0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/imem_ctrl.md
# imem_ctrl

Boot and access controller for the single-cycle core's instruction memory. After reset it holds the core in reset, loads a program into the memory word by word over a valid/ready stream, then releases the core and owns the program counter. While the core runs, it shares the memory's single address port between instruction fetch and a debug read requester, with bounded debug wait. It sits between the instruction memory array, the core's PC/next-PC logic and the debug/loader interface.

## Interface
- DEPTH, 1024: memory depth in 32-bit words; power of two.
- START_PC, 32'h0000_0000: PC value on every entry to RUN.
- MAX_WAIT, 4: cycles a debug request may be refused before it is forced through.

- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset.
- ld_start  in  1  pulse; enter LOAD from IDLE or RUN.
- ld_valid  in  1  loader word valid.
- ld_data  in  32  loader word.
- ld_last  in  1  qualifies final word.
- ld_ready  out  1  controller accepts word.
- load_err  out  1  sticky: memory filled without ld_last.
- mem_addr  out  32  byte address to memory (index = bits [log2(DEPTH)+1:2]).
- mem_we  out  1  memory write strobe.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  combinational read data for mem_addr.
- core_rst_n  out  1  active-low reset to core, registered.
- pc  out  32  current fetch PC.
- instr  out  32  fetched instruction (= mem_rdata when instr_valid).
- instr_valid  out  1  instr is valid this cycle; core must stall when low.
- pc_en  in  1  core advances PC this cycle.
- pc_next  in  32  core's next PC.
- dbg_req  in  1  debug read request, held until granted.
- dbg_addr  in  32  debug byte address.
- dbg_gnt  out  1  debug owns memory port this cycle.
- dbg_rdata  out  32  registered debug read data.
- dbg_rvalid  out  1  one-cycle pulse, cycle after dbg_gnt.

## Operation
- States: IDLE, LOAD, RUN. Reset → IDLE.
- Reset values: state IDLE, core_rst_n 0, ld_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, pc START_PC, instr_valid 0, dbg_gnt 0, dbg_rvalid 0, dbg_rdata 0, load_err 0, word counter 0, wait counter 0.
- IDLE: ld_start → LOAD. Nothing else.
- LOAD: ld_ready = 1. Accept = ld_valid & ld_ready. On accept: mem_we = 1 same cycle (combinational), mem_addr = {cnt, 2'b00}, mem_wdata = ld_data, cnt += 1. Accept with ld_last → RUN. Accept at cnt = DEPTH-1 without ld_last → RUN, load_err set. ld_start ignored. dbg_req never granted.
- LOAD entry: cnt cleared; load_err cleared.
- RUN: core_rst_n = 1 (registered, first high the cycle after entry); pc = START_PC on entry. Default mem_addr = pc, instr_valid = 1, instr = mem_rdata. pc <= pc_next when pc_en & instr_valid; pc_en ignored when instr_valid = 0.
- Debug arbitration (RUN only): grant when dbg_req & (~pc_en | wait = MAX_WAIT). Granted cycle: mem_addr = dbg_addr, dbg_gnt = 1, instr_valid = 0, pc holds; dbg_rdata <= mem_rdata; dbg_rvalid next cycle. Wait counter increments each refused dbg_req cycle, clears on grant or when dbg_req low. At most one grant per two cycles (no back-to-back grants).
- ld_start in RUN → LOAD next cycle; core_rst_n falls with it; pending debug dropped, counter cleared; an in-flight dbg_rvalid still completes.
- Addresses above DEPTH words wrap (upper bits ignored by memory); pc_next bits [1:0] passed through unmodified.

## Timing
- Load write: zero latency, word written on accept edge.
- Last accept at edge N → state RUN after N, core_rst_n = 1 after N+1, first fetch at START_PC in cycle N+1.
- Fetch: combinational, same cycle as pc.
- Debug: grant cycle G, dbg_rvalid/dbg_rdata valid cycle G+1.
- Worst-case debug latency: MAX_WAIT+1 cycles from dbg_req rise.
- rst low at any edge → all reset values after that edge, including mid-LOAD (memory contents not cleared).

## Structure
- Package imem_ctrl_pkg: state enum (IDLE, LOAD, RUN), DEPTH, START_PC, MAX_WAIT defaults, derived index width.
- Sub-module imem_dbg_arb: wait counter, grant decision, back-to-back blocking; top holds FSM, load counter, PC, muxing.

## Test plan
- Reset, then ld_start, 3 words 32'h0064A423, 32'hFFC4A303, 32'h00000013 (last on third) → writes to 0x0, 0x4, 0x8; RUN; core_rst_n high one cycle later; pc = 0, instr = 32'h0064A423.
- Run with pc_en=1, pc_next=pc+4 → instr sequence matches loaded words, one per cycle.
- dbg_req at addr 0x8 while pc_en held 1 → grant on 5th request cycle (MAX_WAIT=4), instr_valid 0 that cycle, pc unchanged, dbg_rvalid next cycle with 32'h00000013.
- dbg_req while pc_en=0 → immediate grant; second held request not granted the following cycle.
- Load DEPTH words with ld_last never set → RUN after word 1023, load_err = 1.
- rst low mid-LOAD after 2 words → IDLE, ld_ready 0, core_rst_n 0; new load restarts at address 0.
